// File: rtl/io_uart_port.sv
// io_uart_port: byte-wide CPU port with TX/RX FIFOs and an 8N1 UART.
// Optional build macro IO_LOOPBACK_EN routes the transmitter back into the receiver.
module io_uart_port #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned FIFO_LOG2   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] io_out_data,
    input  logic       io_out_vld,
    output logic       io_out_rdy,
    output logic [7:0] io_in_data,
    output logic       io_in_vld,
    input  logic       io_in_rdy,
    output logic [4:0] io_err,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned PW    = FIFO_LOG2 + 1;
    localparam int unsigned CW    = $clog2(CLK_PER_BIT);
    localparam int unsigned HALF  = CLK_PER_BIT / 2;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
        return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr, tx_wptr_n, tx_rptr_n;
    logic          tx_push, tx_pop, tx_empty;

    assign tx_push   = io_out_vld && io_out_rdy;
    assign tx_empty  = (tx_wptr == tx_rptr);
    assign tx_wptr_n = tx_wptr + PW'(tx_push);
    assign tx_rptr_n = tx_rptr + PW'(tx_pop);

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[FIFO_LOG2-1:0]] <= io_out_data;
    end

    // ---------------- TX FSM ----------------
    uart_state_t   tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          txd_n, tx_end;

    assign tx_end = (tx_cnt == CW'(CLK_PER_BIT - 1));

    // TX next-state: start pops the FIFO head, stop chains straight into the next frame
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + CW'(1);
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = uart_txd;
        tx_pop     = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_mem[tx_rptr[FIFO_LOG2-1:0]];
                    txd_n      = 1'b0;
                    tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (tx_end) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    txd_n      = tx_shift[0];
                    tx_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_end) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        txd_n      = 1'b1;
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                        txd_n    = tx_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_end) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_mem[tx_rptr[FIFO_LOG2-1:0]];
                        txd_n      = 1'b0;
                        tx_state_n = ST_START;
                    end else begin
                        txd_n      = 1'b1;
                        tx_state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_n      = 1'b1;
                tx_state_n = ST_IDLE;
            end
        endcase
    end

    // ---------------- RX synchronizer ----------------
    logic rx_src, rx_s1, rx_s2, rx_prev;

`ifdef IO_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = uart_rxd;
    assign rx_src     = uart_txd;
`else
    assign rx_src = uart_rxd;
`endif

    // two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wptr, rx_rptr, rx_wptr_n, rx_rptr_n;
    logic          rx_push, rx_pop, rx_full, rx_empty_n;
    logic [7:0]    rx_head_n;

    assign rx_pop     = io_in_vld && io_in_rdy;
    assign rx_full    = ptr_full(rx_wptr, rx_rptr);
    assign rx_wptr_n  = rx_wptr + PW'(rx_push);
    assign rx_rptr_n  = rx_rptr + PW'(rx_pop);
    assign rx_empty_n = (rx_wptr_n == rx_rptr_n);

    // ---------------- RX FSM ----------------
    uart_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_end, set_ovr, set_frm, set_fs;

    assign rx_end = (rx_cnt == CW'(CLK_PER_BIT - 1));

    // head seen after this edge: the byte being pushed when the FIFO drains to it
    assign rx_head_n = (rx_rptr_n == rx_wptr) ? rx_shift : rx_mem[rx_rptr_n[FIFO_LOG2-1:0]];

    // RX storage write
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[FIFO_LOG2-1:0]] <= rx_shift;
    end

    // RX next-state: mid-bit sampling; a low line after a bad stop bit cannot re-arm until it rises
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + CW'(1);
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        set_ovr    = 1'b0;
        set_frm    = 1'b0;
        set_fs     = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = ST_START;
            end
            ST_START: begin
                if (rx_cnt == CW'(HALF - 1)) begin
                    rx_cnt_n = '0;
                    if (rx_s2) begin
                        set_fs     = 1'b1;
                        rx_state_n = ST_IDLE;
                    end else begin
                        rx_bit_n   = 3'd0;
                        rx_state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_end) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_end) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_IDLE;
                    if (!rx_s2)                  set_frm = 1'b1;
                    else if (!rx_full || rx_pop) rx_push = 1'b1;
                    else                         set_ovr = 1'b1;
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    // state, pointer and registered-output update
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state   <= ST_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            uart_txd   <= 1'b1;
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            io_out_rdy <= 1'b0;
            io_in_vld  <= 1'b0;
            io_in_data <= '0;
            io_err     <= '0;
        end else begin
            tx_state   <= tx_state_n;
            tx_cnt     <= tx_cnt_n;
            tx_bit     <= tx_bit_n;
            tx_shift   <= tx_shift_n;
            uart_txd   <= txd_n;
            tx_wptr    <= tx_wptr_n;
            tx_rptr    <= tx_rptr_n;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_wptr    <= rx_wptr_n;
            rx_rptr    <= rx_rptr_n;
            io_out_rdy <= !ptr_full(tx_wptr_n, tx_rptr_n);
            io_in_vld  <= !rx_empty_n;
            if (!rx_empty_n) io_in_data <= rx_head_n;
            io_err     <= {ptr_full(tx_wptr_n, tx_rptr_n),
                           ptr_full(rx_wptr_n, rx_rptr_n),
                           io_err[2] | set_fs,
                           io_err[1] | set_frm,
                           io_err[0] | set_ovr};
        end
    end

endmodule

// File: tb/tb_io_uart_port.sv
// Directed/random bench for io_uart_port with a frame-level reference model.
module tb_io_uart_port;

    localparam int unsigned CPB   = 4;
    localparam int unsigned LOG2  = 2;
    localparam int unsigned DEPTH = 1 << LOG2;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk;
    logic       rstn;
    logic [7:0] io_out_data;
    logic       io_out_vld;
    logic       io_out_rdy;
    logic [7:0] io_in_data;
    logic       io_in_vld;
    logic       io_in_rdy;
    logic [4:0] io_err;
    logic       uart_rxd;
    logic       uart_txd;

    io_uart_port #(.CLK_PER_BIT(CPB), .FIFO_LOG2(LOG2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .io_out_data(io_out_data),
        .io_out_vld (io_out_vld),
        .io_out_rdy (io_out_rdy),
        .io_in_data (io_in_data),
        .io_in_vld  (io_in_vld),
        .io_in_rdy  (io_in_rdy),
        .io_err     (io_err),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tx_log[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] exp_q[$];
    bit         cap_en = 1'b0;

    // serial line recorder, one sample per cycle between active edges
    always @(negedge clk) if (cap_en) tx_log.push_back(uart_txd);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // line level c cycles into the frame of byte b: start 0, data LSB first, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[c / CPB];
    endfunction

    task automatic write_byte(input logic [7:0] d);
        io_out_data = d;
        io_out_vld  = 1'b1;
        tick();
        io_out_vld  = 1'b0;
    endtask

    // log[0] is the line right after the first handshake; frames follow back to back
    task automatic check_stream(input string tag);
        int n;
        logic [63:0] o, e;
        n = tx_bytes.size();
        chk({tag, "_len"}, 64'(tx_log.size() >= 2 + FRAME * n), 64'(1));
        if (tx_log.size() >= 2 + FRAME * n) begin
            chk({tag, "_pre"}, 64'(tx_log[0]), 64'(1));
            for (int b = 0; b < n; b++) begin
                o = '0;
                e = '0;
                for (int c = 0; c < int'(FRAME); c++) begin
                    o[c] = tx_log[1 + FRAME * b + c];
                    e[c] = frame_bit(tx_bytes[b], c);
                end
                chk($sformatf("%s_frame%0d", tag, b), o, e);
            end
            chk({tag, "_post"}, 64'(tx_log[1 + FRAME * n]), 64'(1));
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        uart_rxd = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            ticks(CPB);
        end
        uart_rxd = stop;
        ticks(CPB);
        uart_rxd = 1'b1;
        ticks(2 * CPB);
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 64'(io_in_vld), 64'(1));
        chk({tag, "_data"}, 64'(io_in_data), 64'(exp));
        io_in_rdy = 1'b1;
        tick();
        io_in_rdy = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int n_written, drop_at, budget, waited;

        rstn        = 1'b0;
        io_out_data = '0;
        io_out_vld  = 1'b0;
        io_in_rdy   = 1'b0;
        uart_rxd    = 1'b1;
        ticks(3);

        chk("rst_txd", 64'(uart_txd), 64'(1));
        chk("rst_in_vld", 64'(io_in_vld), 64'(0));
        chk("rst_out_rdy", 64'(io_out_rdy), 64'(0));
        chk("rst_in_data", 64'(io_in_data), 64'(0));
        chk("rst_err", 64'(io_err), 64'(0));
        rstn = 1'b1;
        tick();
        chk("rdy_after_reset", 64'(io_out_rdy), 64'(1));

        // single frames from an idle transmitter
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            tx_log.delete();
            tx_bytes.delete();
            tx_bytes.push_back(d);
            write_byte(d);
            cap_en = 1'b1;
            ticks(FRAME + 3);
            cap_en = 1'b0;
            check_stream($sformatf("tx_single%0d", k));
        end

        // burst: one byte leaves for the shifter the edge after its write, so DEPTH+1 writes fill the FIFO
        tx_log.delete();
        tx_bytes.delete();
        d = 8'($urandom);
        tx_bytes.push_back(d);
        write_byte(d);
        cap_en    = 1'b1;
        n_written = 1;
        drop_at   = -1;
        budget    = 200;
        while (n_written < 6 && budget > 0) begin
            if (io_out_rdy) begin
                d = 8'($urandom);
                tx_bytes.push_back(d);
                write_byte(d);
                n_written++;
            end else begin
                if (drop_at < 0) begin
                    drop_at = n_written;
                    chk("tx_full_flag", 64'(io_err[4]), 64'(1));
                end
                tick();
                budget--;
            end
        end
        chk("tx_burst_budget", 64'(budget > 0), 64'(1));
        chk("tx_full_point", 64'(drop_at), 64'(DEPTH + 1));
        ticks(6 * FRAME);
        cap_en = 1'b0;
        check_stream("tx_burst");
        chk("tx_full_clear", 64'(io_err[4]), 64'(0));

`ifndef IO_LOOPBACK_EN
        // receive single frames
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 8'h3C : 8'($urandom);
            rx_frame(d, 1'b1);
            read_expect($sformatf("rx_single%0d", k), d);
            chk($sformatf("rx_single%0d_drained", k), 64'(io_in_vld), 64'(0));
        end
        chk("rx_no_err", 64'(io_err), 64'(0));

        // overrun: FIFO keeps the first DEPTH bytes, later ones are dropped
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            rx_frame(d, 1'b1);
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
        end
        chk("rx_overrun_flag", 64'(io_err[0]), 64'(1));
        chk("rx_full_flag", 64'(io_err[3]), 64'(1));
        for (int k = 0; k < int'(DEPTH); k++) read_expect($sformatf("rx_ovr%0d", k), exp_q[k]);
        chk("rx_ovr_drained", 64'(io_in_vld), 64'(0));
        chk("rx_err_after_drain", 64'(io_err), 64'(5'b00001));

        // framing error: bad stop bit pushes nothing
        rx_frame(8'($urandom), 1'b0);
        chk("rx_frame_nopush", 64'(io_in_vld), 64'(0));
        chk("rx_frame_flag", 64'(io_err[1]), 64'(1));

        // one-cycle glitch is a false start
        uart_rxd = 1'b0;
        tick();
        uart_rxd = 1'b1;
        ticks(3 * CPB);
        chk("rx_glitch_nopush", 64'(io_in_vld), 64'(0));
        chk("rx_glitch_flag", 64'(io_err), 64'(5'b00111));

        // receiver still works after errors
        d = 8'($urandom);
        rx_frame(d, 1'b1);
        read_expect("rx_recover", d);
`else
        // loopback: transmitted bytes come back on the receive side
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 8'h5A : 8'($urandom);
            write_byte(d);
            waited = 0;
            while (!io_in_vld && waited < 80) begin
                tick();
                waited++;
            end
            chk($sformatf("lb%0d_arrived", k), 64'(io_in_vld), 64'(1));
            chk($sformatf("lb%0d_latency", k), 64'(waited >= 38 && waited <= 45), 64'(1));
            read_expect($sformatf("lb%0d", k), d);
            ticks(2 * CPB);
        end
`endif

        // reset in the middle of a transmitted frame
        write_byte(8'h00);
        ticks(15);
        chk("midrst_busy", 64'(uart_txd), 64'(0));
        rstn = 1'b0;
        tick();
        chk("midrst_txd", 64'(uart_txd), 64'(1));
        chk("midrst_err", 64'(io_err), 64'(0));
        chk("midrst_in_vld", 64'(io_in_vld), 64'(0));
        chk("midrst_out_rdy", 64'(io_out_rdy), 64'(0));
        rstn = 1'b1;
        waited = 0;
        for (int k = 0; k < int'(FRAME) + 10; k++) begin
            tick();
            if (!uart_txd || io_in_vld) waited++;
        end
        chk("midrst_quiet", 64'(waited), 64'(0));
        chk("midrst_rdy", 64'(io_out_rdy), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
